// File: rtl/utf8_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : utf8_decoder
//  Description : Byte FIFO followed by a UTF-8 decoder FSM. Bytes arrive on a
//                one-cycle strobe with no backpressure. Each character leaves as
//                a 21-bit code point on a valid/ready slot. Malformed or
//                truncated sequences produce REPLACEMENT with an error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module utf8_decoder #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [20:0] REPLACEMENT = 21'h00FFFD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        oe,
  output logic [20:0] codepoint,
  output logic        codepoint_valid,
  input  logic        codepoint_ready,
  output logic        codepoint_error,
  output logic        overflow
);

  localparam int             AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_LEAD = 1'b0,
    ST_CONT = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Byte FIFO: pointers carry one extra bit so full and empty are distinct.
  // ---------------------------------------------------------------------------
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        overflow_q;

  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic [7:0]  w_head;

  assign w_count = wr_ptr_q - rd_ptr_q;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == FULL_COUNT);
  // A write on a full FIFO still lands when the decoder frees a slot this cycle.
  assign w_push  = oe && (!w_full || w_pop);
  assign w_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

  // Storage array; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= data;
    end
  end

  // Pointer bookkeeping and sticky overflow on a dropped byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (oe && w_full && !w_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder state. Only the low 15 accumulator bits are ever held: the final
  // continuation byte supplies the last 6 bits directly into the emitted value.
  // ---------------------------------------------------------------------------
  state_e      state_q,  state_d;
  logic [14:0] acc_q,    acc_d;
  logic [1:0]  rem_q,    rem_d;
  logic [7:0]  lead_q,   lead_d;
  logic        first_q,  first_d;
  logic [20:0] cp_q;
  logic        err_q;
  logic        valid_q;

  logic        w_can_consume;
  logic [7:0]  w_lo;
  logic [7:0]  w_hi;
  logic        w_cont_ok;
  logic [20:0] w_shift;
  logic        w_emit;
  logic [20:0] w_emit_cp;
  logic        w_emit_err;

  assign w_can_consume = !valid_q || codepoint_ready;
  assign w_shift       = {acc_q, w_head[5:0]};

  // Legal continuation window; only the first continuation is narrowed by lead.
  always_comb begin
    w_lo = 8'h80;
    w_hi = 8'hBF;
    if (first_q) begin
      case (lead_q)
        8'hE0:   w_lo = 8'hA0;
        8'hED:   w_hi = 8'h9F;
        8'hF0:   w_lo = 8'h90;
        8'hF4:   w_hi = 8'h8F;
        default: ;
      endcase
    end
  end

  assign w_cont_ok = (w_head >= w_lo) && (w_head <= w_hi);

  // Next-state, pop and emit decisions for one byte per cycle.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    lead_d     = lead_q;
    first_d    = first_q;
    w_pop      = 1'b0;
    w_emit     = 1'b0;
    w_emit_cp  = '0;
    w_emit_err = 1'b0;
    if (w_can_consume && !w_empty) begin
      case (state_q)
        ST_LEAD: begin
          w_pop   = 1'b1;
          lead_d  = w_head;
          first_d = 1'b1;
          if (w_head <= 8'h7F) begin
            w_emit    = 1'b1;
            w_emit_cp = {13'b0, w_head};
          end else if (w_head >= 8'hC2 && w_head <= 8'hDF) begin
            acc_d   = {10'b0, w_head[4:0]};
            rem_d   = 2'd1;
            state_d = ST_CONT;
          end else if (w_head >= 8'hE0 && w_head <= 8'hEF) begin
            acc_d   = {11'b0, w_head[3:0]};
            rem_d   = 2'd2;
            state_d = ST_CONT;
          end else if (w_head >= 8'hF0 && w_head <= 8'hF4) begin
            acc_d   = {12'b0, w_head[2:0]};
            rem_d   = 2'd3;
            state_d = ST_CONT;
          end else begin
            w_emit     = 1'b1;
            w_emit_cp  = REPLACEMENT;
            w_emit_err = 1'b1;
          end
        end
        ST_CONT: begin
          if (w_cont_ok) begin
            w_pop   = 1'b1;
            acc_d   = w_shift[14:0];
            rem_d   = rem_q - 2'd1;
            first_d = 1'b0;
            if (rem_q == 2'd1) begin
              w_emit    = 1'b1;
              w_emit_cp = w_shift;
              state_d   = ST_LEAD;
            end
          end else begin
            // Offending byte stays in the FIFO and is re-read as a lead byte.
            w_emit     = 1'b1;
            w_emit_cp  = REPLACEMENT;
            w_emit_err = 1'b1;
            state_d    = ST_LEAD;
          end
        end
        default: state_d = ST_LEAD;
      endcase
    end
  end

  // FSM registers and the registered output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LEAD;
      acc_q   <= '0;
      rem_q   <= '0;
      lead_q  <= '0;
      first_q <= 1'b0;
      cp_q    <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      lead_q  <= lead_d;
      first_q <= first_d;
      if (w_emit) begin
        cp_q    <= w_emit_cp;
        err_q   <= w_emit_err;
        valid_q <= 1'b1;
      end else if (codepoint_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign codepoint       = cp_q;
  assign codepoint_error = err_q;
  assign codepoint_valid = valid_q;
  assign overflow        = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_utf8_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_utf8_decoder
//  Description : Self-checking bench for utf8_decoder: directed vector table,
//                multi-cycle corner sequences and a randomized stream checked
//                against a stream-level reference decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_utf8_decoder;

  localparam int          DEPTH = 16;
  localparam logic [21:0] BAD   = {1'b1, 21'h00FFFD};
  localparam int          NCHAR = 10000;
  localparam int          LIMIT = 95000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data;
  logic        oe;
  logic [20:0] codepoint;
  logic        codepoint_valid;
  logic        codepoint_ready;
  logic        codepoint_error;
  logic        overflow;

  always #5 clk = ~clk;

  utf8_decoder #(.FIFO_DEPTH(DEPTH), .REPLACEMENT(21'h00FFFD)) dut (
    .clk             (clk),
    .reset           (reset),
    .data            (data),
    .oe              (oe),
    .codepoint       (codepoint),
    .codepoint_valid (codepoint_valid),
    .codepoint_ready (codepoint_ready),
    .codepoint_error (codepoint_error),
    .overflow        (overflow)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [21:0] got[$];
  logic [21:0] expq[$];
  logic [7:0]  stream[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 50) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Output monitor: collects handshakes and checks the slot holds while stalled.
  logic        pv = 1'b0, pr = 1'b0, prst = 1'b1, perr = 1'b0;
  logic [20:0] pcp = '0;
  always @(negedge clk) begin
    if (!reset && pv && !pr && !prst)
      check("hold", {9'b0, codepoint_valid, codepoint_error, codepoint}, {9'b0, 1'b1, perr, pcp});
    if (!reset && codepoint_valid && codepoint_ready)
      got.push_back({codepoint_error, codepoint});
    pv   = codepoint_valid;
    pr   = codepoint_ready;
    prst = reset;
    perr = codepoint_error;
    pcp  = codepoint;
  end

  // Stream-level reference decoder: walks the byte list by the UTF-8 rules.
  function automatic void ref_decode();
    int i, n, b, c, need, cp, lo, hi, j;
    bit ok;
    i = 0;
    n = stream.size();
    while (i < n) begin
      b = int'(stream[i]);
      if (b < 128) begin
        expq.push_back({1'b0, 21'(b)});
        i++;
        continue;
      end
      if (b >= 'hC2 && b <= 'hDF)      begin need = 1; cp = b % 32; end
      else if (b >= 'hE0 && b <= 'hEF) begin need = 2; cp = b % 16; end
      else if (b >= 'hF0 && b <= 'hF4) begin need = 3; cp = b % 8;  end
      else begin
        expq.push_back(BAD);
        i++;
        continue;
      end
      lo = 'h80; hi = 'hBF;
      if (b == 'hE0) lo = 'hA0;
      if (b == 'hED) hi = 'h9F;
      if (b == 'hF0) lo = 'h90;
      if (b == 'hF4) hi = 'h8F;
      j  = i + 1;
      ok = 1'b1;
      for (int k = 0; k < need; k++) begin
        if (j >= n) return;  // incomplete tail stays pending
        c = int'(stream[j]);
        if (c < lo || c > hi) begin
          ok = 1'b0;
          break;
        end
        cp = cp * 64 + (c % 64);
        j++;
        lo = 'h80; hi = 'hBF;
      end
      expq.push_back(ok ? {1'b0, 21'(cp)} : BAD);
      i = j;
    end
  endfunction

  // Encode one random scalar value into the stream.
  task automatic push_char();
    int cls, cp;
    cls = $urandom_range(0, 3);
    case (cls)
      0: cp = $urandom_range(0, 127);
      1: cp = $urandom_range(128, 2047);
      2: begin
        cp = $urandom_range(2048, 65535);
        while (cp >= 'hD800 && cp <= 'hDFFF) cp = $urandom_range(2048, 65535);
      end
      default: cp = $urandom_range(65536, 'h10FFFF);
    endcase
    if (cp < 128) stream.push_back(8'(cp));
    else if (cp < 2048) begin
      stream.push_back(8'('hC0 + cp / 64));
      stream.push_back(8'('h80 + cp % 64));
    end else if (cp < 65536) begin
      stream.push_back(8'('hE0 + cp / 4096));
      stream.push_back(8'('h80 + (cp / 64) % 64));
      stream.push_back(8'('h80 + cp % 64));
    end else begin
      stream.push_back(8'('hF0 + cp / 262144));
      stream.push_back(8'('h80 + (cp / 4096) % 64));
      stream.push_back(8'('h80 + (cp / 64) % 64));
      stream.push_back(8'('h80 + cp % 64));
    end
  endtask

  task automatic send(input logic [7:0] b);
    oe   = 1'b1;
    data = b;
    @(posedge clk); #1;
    oe   = 1'b0;
  endtask

  typedef struct {
    logic [31:0] bytes;  // first byte in [31:24]
    int          nb;
    logic [43:0] exp;    // first result in [43:22]
    int          ne;
  } vec_t;

  vec_t vecs[16];
  int   cyc;

  initial begin
    vecs[0]  = '{32'h4100_0000, 1, {22'h000041, 22'h0}, 1};
    vecs[1]  = '{32'hC3A9_0000, 2, {22'h0000E9, 22'h0}, 1};
    vecs[2]  = '{32'hF09F_9880, 4, {22'h01F600, 22'h0}, 1};
    vecs[3]  = '{32'hE241_0000, 2, {BAD, 22'h000041}, 2};
    vecs[4]  = '{32'hE080_0000, 2, {BAD, BAD}, 2};
    vecs[5]  = '{32'hEDA0_0000, 2, {BAD, BAD}, 2};
    vecs[6]  = '{32'h8000_0000, 1, {BAD, 22'h0}, 1};
    vecs[7]  = '{32'hF800_0000, 1, {BAD, 22'h0}, 1};
    vecs[8]  = '{32'hED9F_BF00, 3, {22'h00D7FF, 22'h0}, 1};
    vecs[9]  = '{32'hF48F_BFBF, 4, {22'h10FFFF, 22'h0}, 1};
    vecs[10] = '{32'hF490_0000, 2, {BAD, BAD}, 2};
    vecs[11] = '{32'hC100_0000, 1, {BAD, 22'h0}, 1};
    vecs[12] = '{32'hC280_0000, 2, {22'h000080, 22'h0}, 1};
    vecs[13] = '{32'hEFBF_BF00, 3, {22'h00FFFF, 22'h0}, 1};
    vecs[14] = '{32'hE0A0_8000, 3, {22'h000800, 22'h0}, 1};
    vecs[15] = '{32'hF090_8080, 4, {22'h010000, 22'h0}, 1};

    reset = 1'b1; oe = 1'b0; data = 8'h00; codepoint_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", {31'b0, codepoint_valid}, 32'd0);
    check("reset error", {31'b0, codepoint_error}, 32'd0);
    check("reset cp", {11'b0, codepoint}, 32'd0);
    check("reset overflow", {31'b0, overflow}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Latency: oe in cycle N, valid visible in cycle N+2, then clears.
    send(8'h41);
    @(negedge clk);
    check("lat N+1 valid", {31'b0, codepoint_valid}, 32'd0);
    @(negedge clk);
    check("lat N+2 valid", {31'b0, codepoint_valid}, 32'd1);
    check("lat cp", {11'b0, codepoint}, 32'h41);
    check("lat error", {31'b0, codepoint_error}, 32'd0);
    @(negedge clk);
    check("lat clear", {31'b0, codepoint_valid}, 32'd0);
    @(posedge clk); #1;

    // Directed vector table.
    for (int v = 0; v < 16; v++) begin
      logic [31:0] bv;
      logic [43:0] ev;
      got.delete();
      bv = vecs[v].bytes;
      ev = vecs[v].exp;
      for (int k = 0; k < vecs[v].nb; k++) send(bv[31-8*k -: 8]);
      repeat (8) @(posedge clk);
      #1;
      check($sformatf("vec%0d count", v), got.size(), vecs[v].ne);
      for (int e = 0; e < vecs[v].ne; e++)
        check($sformatf("vec%0d out%0d", v, e),
              (e < got.size()) ? {10'b0, got[e]} : 32'hDEAD_BEEF,
              {10'b0, ev[43-22*e -: 22]});
    end

    // Overflow: first byte goes straight into the free output slot, DEPTH more
    // fill the FIFO, the last of DEPTH+2 is dropped.
    got.delete();
    codepoint_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) send(8'(8'h41 + i));
    @(posedge clk); #1;
    check("ovf set", {31'b0, overflow}, 32'd1);
    codepoint_ready = 1'b1;
    repeat (DEPTH + 10) @(posedge clk);
    #1;
    check("ovf drain count", got.size(), DEPTH + 1);
    for (int i = 0; i < DEPTH + 1; i++)
      check($sformatf("ovf out%0d", i),
            (i < got.size()) ? {10'b0, got[i]} : 32'hDEAD_BEEF, 32'(8'h41 + i));
    check("ovf sticky", {31'b0, overflow}, 32'd1);

    // Reset discards a partial sequence.
    got.delete();
    send(8'hC3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst valid", {31'b0, codepoint_valid}, 32'd0);
    check("rst overflow", {31'b0, overflow}, 32'd0);
    send(8'h41);
    repeat (6) @(posedge clk);
    #1;
    check("rst count", got.size(), 1);
    check("rst out", (got.size() > 0) ? {10'b0, got[0]} : 32'hDEAD_BEEF, 32'h41);

    // Randomized stream with occasional garbage bytes.
    got.delete();
    stream.delete();
    expq.delete();
    for (int c = 0; c < NCHAR; c++) begin
      if ($urandom_range(0, 15) == 0) stream.push_back(8'($urandom_range(128, 255)));
      push_char();
    end
    ref_decode();
    cyc = 0;
    fork
      begin
        for (int i = 0; i < stream.size(); i++) begin
          while ($urandom_range(0, 9) < 4) begin @(posedge clk); #1; end
          send(stream[i]);
        end
      end
      begin
        while (got.size() < expq.size() && cyc < LIMIT) begin
          codepoint_ready = ($urandom_range(0, 9) != 0);
          @(posedge clk); #1;
          cyc++;
        end
        codepoint_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("rand count", got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      check($sformatf("rand out%0d", i),
            (i < got.size()) ? {10'b0, got[i]} : 32'hDEAD_BEEF, {10'b0, expq[i]});
    check("rand no overflow", {31'b0, overflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
